// File: rtl/matrix_order_stream.sv
// Serial valid/ready element loader that fills a zero-padded MAX_DIM x MAX_DIM
// row-major buffer, optionally transposing each r x c matrix on the way in.
module matrix_order_stream #(
    parameter int DATA_WIDTH = 9,
    parameter int MAX_DIM    = 5,
    parameter int DIM_W      = $clog2(MAX_DIM + 1)
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  start,
    input  logic [DIM_W-1:0]                      r,
    input  logic [DIM_W-1:0]                      c,
    input  logic                                  transpose,
    input  logic                                  in_valid,
    input  logic [DATA_WIDTH-1:0]                 in_data,
    output logic                                  in_ready,
    output logic [MAX_DIM*MAX_DIM*DATA_WIDTH-1:0] data_out,
    output logic                                  out_valid,
    output logic                                  done,
    output logic                                  busy,
    output logic                                  err
);

    localparam int SLOTS = MAX_DIM * MAX_DIM;
    localparam int IDX_W = $clog2(SLOTS);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_t;

    state_t state, next_state;

    logic [DIM_W-1:0]      row_q, col_q;
    logic [DIM_W-1:0]      r_q, c_q;
    logic                  tr_q;
    logic [DATA_WIDTH-1:0] mem [SLOTS];

    logic in_ready_q, out_valid_q, done_q, busy_q, err_q;
    logic in_ready_d, out_valid_d, done_d, busy_d, err_d;

    logic             start_seen;
    logic             dims_bad;
    logic             accept;
    logic             reject;
    logic             xfer;
    logic             last_col;
    logic             last_row;
    logic             last_xfer;
    logic [IDX_W-1:0] wr_idx;

    // Start is only looked at when no matrix is being loaded.
    always_comb begin
        start_seen = start && ((state == IDLE) || (state == DONE));
        dims_bad   = (r == '0) || (c == '0) ||
                     (r > DIM_W'(MAX_DIM)) || (c > DIM_W'(MAX_DIM));
        accept     = start_seen && !dims_bad;
        reject     = start_seen && dims_bad;
        xfer       = (state == LOAD) && in_valid && in_ready_q;
        last_col   = (col_q == (c_q - DIM_W'(1)));
        last_row   = (row_q == (r_q - DIM_W'(1)));
        last_xfer  = xfer && last_col && last_row;
    end

    always_comb begin
        if (tr_q)
            wr_idx = IDX_W'(col_q) * IDX_W'(MAX_DIM) + IDX_W'(row_q);
        else
            wr_idx = IDX_W'(row_q) * IDX_W'(MAX_DIM) + IDX_W'(col_q);
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept)    next_state = LOAD;
            LOAD:    if (last_xfer) next_state = DONE;
            DONE:    if (accept)    next_state = LOAD;
            default:                next_state = IDLE;
        endcase
    end

    // Output logic: next values of the registered status outputs
    always_comb begin
        in_ready_d  = (next_state == LOAD);
        busy_d      = (next_state == LOAD);
        done_d      = last_xfer;
        err_d       = reject;
        out_valid_d = out_valid_q;
        if (accept)
            out_valid_d = 1'b0;
        else if (last_xfer)
            out_valid_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    // Latched matrix shape and element position counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q   <= '0;
            c_q   <= '0;
            tr_q  <= 1'b0;
            row_q <= '0;
            col_q <= '0;
        end else if (accept) begin
            r_q   <= r;
            c_q   <= c;
            tr_q  <= transpose;
            row_q <= '0;
            col_q <= '0;
        end else if (xfer) begin
            if (last_col) begin
                col_q <= '0;
                row_q <= row_q + DIM_W'(1);
            end else begin
                col_q <= col_q + DIM_W'(1);
            end
        end
    end

    // Clearing on every accepted start keeps all unused slots at zero.
    always_ff @(posedge clk) begin
        if (!rst_n || accept) begin
            for (int unsigned k = 0; k < SLOTS; k++)
                mem[k] <= '0;
        end else if (xfer) begin
            mem[wr_idx] <= in_data;
        end
    end

    for (genvar k = 0; k < SLOTS; k++) begin : g_flat
        assign data_out[k*DATA_WIDTH +: DATA_WIDTH] = mem[k];
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign err       = err_q;

endmodule

// File: doc/matrix_order_stream.md
Name: matrix_order_stream

Overview:
- Sequential, parametrised successor to the combinational 5x5 reorder stage.
- Accepts an r x c matrix as a serial valid/ready element stream and places each element into a zero-padded MAX_DIM x MAX_DIM row-major buffer.
- Optionally transposes the matrix during placement.
- Sits between the element input/collection path and the matrix compute and display units, which consume the padded flat bus.

Parameters:
- DATA_WIDTH, 9, width of one matrix element.
- MAX_DIM, 5, maximum rows and columns; the buffer holds MAX_DIM*MAX_DIM slots.
- DIM_W, $clog2(MAX_DIM+1), width of the r and c ports.

Ports:
- clk  input  1  system clock; all logic updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  one-cycle request to begin a new matrix; honoured only in IDLE or DONE.
- r  input  DIM_W  row count, sampled on an accepted start.
- c  input  DIM_W  column count, sampled on an accepted start.
- transpose  input  1  sampled on an accepted start; 1 places element (i,j) at slot j*MAX_DIM+i.
- in_valid  input  1  in_data holds a valid element.
- in_data  input  DATA_WIDTH  element stream, row-major order of the source matrix.
- in_ready  output  1  block can accept an element this cycle.
- data_out  output  MAX_DIM*MAX_DIM*DATA_WIDTH  flat padded buffer; slot k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- out_valid  output  1  data_out holds a complete matrix.
- done  output  1  one-cycle pulse when the last element is written.
- busy  output  1  high while in LOAD.
- err  output  1  one-cycle pulse when a start is rejected for illegal dimensions.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - State goes to IDLE.
  - All buffer slots, row/col counters, latched r/c/transpose, in_ready, out_valid, done, busy and err go to 0.
  - Reset wins over every other input in the same cycle.
  - Reset during LOAD aborts the matrix; no done pulse is produced.
- States: IDLE, LOAD, DONE.
- IDLE or DONE with start=1:
  - If r==0, c==0, r>MAX_DIM or c>MAX_DIM: err=1 for the next cycle. State, buffer and out_valid are unchanged (a DONE result is preserved).
  - Otherwise: latch r, c and transpose; clear all slots to 0; zero the row/col counters; set out_valid=0; go to LOAD.
- LOAD:
  - in_ready=1 and busy=1. in_ready is a registered state decode: high in every LOAD cycle, low otherwise.
  - Transfer occurs on in_valid && in_ready.
  - On transfer, the element at (row,col) is written to slot row*MAX_DIM+col, or to col*MAX_DIM+row when transpose=1.
  - After each transfer: col increments. When col==c-1, col wraps to 0 and row increments.
  - The transfer at (r-1,c-1) moves the state to DONE. In the following cycle done=1 for exactly one cycle and out_valid=1.
  - start is ignored in LOAD.
  - in_valid=0 stalls indefinitely with no timeout; counters hold.
- DONE:
  - in_ready=0; out_valid=1; data_out is held.
  - Stays in DONE until the next accepted start, which clears the buffer in the same edge.
  - A rejected start in DONE keeps out_valid=1.
- Transposed output for an r x c input is the c x r matrix, padded; rows and columns beyond it remain 0.
- Unused slots are always 0 after a matrix completes.
- Latency:
  - Valid start to in_ready=1: 1 cycle.
  - Last transfer to done/out_valid: 1 cycle.
  - Minimum total: r*c+2 cycles.
- data_out is visible during LOAD as a partially filled buffer. Consumers qualify it with out_valid.
- Counter widths are DIM_W; no arithmetic overflow is possible for legal dimensions.

Test Plan:
- Reset mid-stream: start r=3,c=3; send 4 elements; assert rst_n=0 for one cycle -> all outputs 0, state IDLE, no done pulse; a new start then works normally.
- Normal 2x3: send 1,2,3,4,5,6 with transpose=0 -> slots 0,1,2=1,2,3; slots 5,6,7=4,5,6; all other slots 0; done pulses once, 1 cycle after the 6th transfer; out_valid=1.
- Transpose 2x3: same stream with transpose=1 -> slots 0,5,10=1,2,3; slots 1,6,11=4,5,6; all other slots 0.
- Full 5x5 with random in_valid gaps: elements 0..24 -> slot k=k; in_ready deasserted in DONE; no element is lost or duplicated across stalls.
- Illegal dimensions: start with r=0,c=2, then with r=6,c=1 while in DONE holding a prior result -> err pulses one cycle each; state and data_out unchanged; out_valid stays 1.
- start asserted during LOAD and simultaneously with the final transfer -> ignored; done pulses normally; the buffer contains only the original matrix.
